// File: rtl/gpio_in_filter.sv
// GPIO input conditioner: per-bit synchroniser, debounce filter, edge pulses,
// sticky pending flags and a maskable interrupt line.
module gpio_in_filter #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pad_i,
  input  logic             byp_i,
  input  logic [WIDTH-1:0] irq_mask_i,
  input  logic [WIDTH-1:0] pend_clr_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] pend_o,
  output logic             irq_o
);

  // Terminal count: a level differing for DEB_CYCLES consecutive cycles is accepted.
  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [7:0]       cnt_q  [WIDTH];
  logic [7:0]       cnt_d  [WIDTH];
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] gpio_d;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_d;
  logic [WIDTH-1:0] pend_d;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: pad levels shift through SYNC_STAGES flops per bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= pad_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Debounce decision per bit, plus the edge and pending values to register.
  always_comb begin
    gpio_d = gpio_o;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (byp_i) begin
        gpio_d[i] = sync_s[i];
        cnt_d[i]  = 8'd0;
      end else if (sync_s[i] == gpio_o[i]) begin
        cnt_d[i] = 8'd0;
      end else if (cnt_q[i] == DEB_LAST) begin
        gpio_d[i] = sync_s[i];
        cnt_d[i]  = 8'd0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
    rise_d = gpio_d & ~gpio_o;
    fall_d = ~gpio_d & gpio_o;
    pend_d = (pend_o & ~pend_clr_i) | rise_d | fall_d;
  end

  // Filter state and registered outputs; reset discards any running count.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= 8'd0;
      gpio_o <= '0;
      rise_o <= '0;
      fall_o <= '0;
      pend_o <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      gpio_o <= gpio_d;
      rise_o <= rise_d;
      fall_o <= fall_d;
      pend_o <= pend_d;
    end
  end

  assign irq_o = |(pend_o & irq_mask_i);

endmodule

// File: tb/tb_gpio_in_filter.sv
// Self-checking bench for gpio_in_filter: an abstract per-cycle model plus
// directed scenarios with hand-computed expectations.
module tb_gpio_in_filter;

  localparam int WIDTH       = 32;
  localparam int SYNC_STAGES = 2;
  localparam int DEB_CYCLES  = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] pad_i = '0;
  logic             byp_i = 1'b0;
  logic [WIDTH-1:0] irq_mask_i = '0;
  logic [WIDTH-1:0] pend_clr_i = '0;
  logic [WIDTH-1:0] gpio_o;
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;
  logic [WIDTH-1:0] pend_o;
  logic             irq_o;

  int n_vec = 0;
  int n_err = 0;

  gpio_in_filter #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .pad_i(pad_i), .byp_i(byp_i),
    .irq_mask_i(irq_mask_i), .pend_clr_i(pend_clr_i),
    .gpio_o(gpio_o), .rise_o(rise_o), .fall_o(fall_o), .pend_o(pend_o),
    .irq_o(irq_o)
  );

  always #5 clock = ~clock;

  // Model state: expected outputs after the most recent rising edge.
  logic [WIDTH-1:0] pad_delay [SYNC_STAGES];
  logic [WIDTH-1:0] seen_hist [$];
  logic [WIDTH-1:0] m_gpio = '0;
  logic [WIDTH-1:0] m_rise = '0;
  logic [WIDTH-1:0] m_fall = '0;
  logic [WIDTH-1:0] m_pend = '0;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a level is taken once the synchronised pad has disagreed with the
  // filtered value on each of the last DEB_CYCLES edges; bypass copies it.
  always @(posedge clock) begin
    logic [WIDTH-1:0] seen;
    logic [WIDTH-1:0] nxt;
    bit               all_diff;
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) pad_delay[k] = '0;
      seen_hist.delete();
      repeat (DEB_CYCLES) seen_hist.push_back('0);
      m_gpio = '0; m_rise = '0; m_fall = '0; m_pend = '0;
    end else begin
      seen = pad_delay[SYNC_STAGES-1];
      for (int k = SYNC_STAGES-1; k > 0; k--) pad_delay[k] = pad_delay[k-1];
      pad_delay[0] = pad_i;
      seen_hist.push_back(seen);
      if (seen_hist.size() > DEB_CYCLES) void'(seen_hist.pop_front());
      if (byp_i) begin
        nxt = seen;
      end else begin
        nxt = m_gpio;
        for (int i = 0; i < WIDTH; i++) begin
          all_diff = 1'b1;
          foreach (seen_hist[j]) if (seen_hist[j][i] == m_gpio[i]) all_diff = 1'b0;
          if (all_diff) nxt[i] = ~m_gpio[i];
        end
      end
      m_rise = nxt & ~m_gpio;
      m_fall = ~nxt & m_gpio;
      m_pend = (m_pend & ~pend_clr_i) | m_rise | m_fall;
      m_gpio = nxt;
    end
  end

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clock) begin
    check_output("model_gpio", gpio_o, m_gpio);
    check_output("model_rise", rise_o, m_rise);
    check_output("model_fall", fall_o, m_fall);
    check_output("model_pend", pend_o, m_pend);
    check_output("model_irq", {31'd0, irq_o}, {31'd0, |(m_pend & irq_mask_i)});
    check_output("rise_fall_excl", rise_o & fall_o, 32'd0);
  end

  // Advance n cycles; land just after a falling edge for driving and checks.
  task automatic apply_stimulus(input int n);
    repeat (n) @(negedge clock);
    #2;
  endtask

  initial begin
    apply_stimulus(2);
    check_output("rst_gpio", gpio_o, 32'd0);
    check_output("rst_pend", pend_o, 32'd0);
    check_output("rst_irq", {31'd0, irq_o}, 32'd0);
    reset = 1'b0;

    // 1: single rising edge on bit 3, latency 18 edges, masked-in interrupt.
    pad_i[3] = 1'b1; irq_mask_i[3] = 1'b1;
    apply_stimulus(17);
    check_output("t1_gpio_before", {31'd0, gpio_o[3]}, 32'd0);
    apply_stimulus(1);
    check_output("t1_gpio", {31'd0, gpio_o[3]}, 32'd1);
    check_output("t1_rise", rise_o, 32'h0000_0008);
    check_output("t1_pend", pend_o, 32'h0000_0008);
    check_output("t1_irq", {31'd0, irq_o}, 32'd1);
    apply_stimulus(1);
    check_output("t1_rise_once", rise_o, 32'd0);

    // 2: glitches shorter than the debounce window never reach the output.
    pad_i[5] = 1'b1; apply_stimulus(10);
    pad_i[5] = 1'b0; apply_stimulus(20);
    check_output("t2_glitch10", {30'd0, pend_o[5], gpio_o[5]}, 32'd0);
    repeat (3) begin
      pad_i[5] = 1'b1; apply_stimulus(15);
      pad_i[5] = 1'b0; apply_stimulus(5);
    end
    apply_stimulus(20);
    check_output("t2_glitch15", {30'd0, pend_o[5], gpio_o[5]}, 32'd0);
    pad_i[5] = 1'b1; apply_stimulus(16);
    pad_i[5] = 1'b0; apply_stimulus(20);
    check_output("t2_pulse16", {31'd0, pend_o[5]}, 32'd1);

    // 3: set/clear collision on bit 0 keeps the flag; a later clear drops irq.
    pend_clr_i = '1; apply_stimulus(1);
    pend_clr_i = '0; irq_mask_i = 32'h0000_0001;
    check_output("t3_cleared", pend_o, 32'd0);
    pad_i[0] = 1'b1; apply_stimulus(20);
    pend_clr_i[0] = 1'b1; apply_stimulus(1);
    pend_clr_i[0] = 1'b0;
    check_output("t3_pre_clear", {31'd0, pend_o[0]}, 32'd0);
    pad_i[0] = 1'b0; apply_stimulus(17);
    pend_clr_i[0] = 1'b1; apply_stimulus(1);
    check_output("t3_fall", fall_o, 32'h0000_0001);
    check_output("t3_collide", {31'd0, pend_o[0]}, 32'd1);
    check_output("t3_irq_on", {31'd0, irq_o}, 32'd1);
    apply_stimulus(1);
    check_output("t3_clr", {31'd0, pend_o[0]}, 32'd0);
    check_output("t3_irq_off", {31'd0, irq_o}, 32'd0);
    pend_clr_i = '0;

    // 4: bypass passes the synchronised level after 3 edges.
    reset = 1'b1; apply_stimulus(1);
    reset = 1'b0; byp_i = 1'b1; pad_i = 32'hA5A5_0F0F;
    apply_stimulus(2);
    check_output("t4_gpio_early", gpio_o, 32'd0);
    apply_stimulus(1);
    check_output("t4_gpio", gpio_o, 32'hA5A5_0F0F);
    check_output("t4_rise", rise_o, 32'hA5A5_0F0F);
    pad_i = 32'h5A5A_F0F0; apply_stimulus(3);
    check_output("t4_gpio2", gpio_o, 32'h5A5A_F0F0);
    check_output("t4_rise2", rise_o, 32'h5A5A_F0F0);
    check_output("t4_fall2", fall_o, 32'hA5A5_0F0F);
    byp_i = 1'b0; pad_i = 32'd0; apply_stimulus(10);
    byp_i = 1'b1; apply_stimulus(1);
    byp_i = 1'b0; apply_stimulus(20);

    // 5: reset mid-count on bit 7 loses the count; a fresh count follows.
    reset = 1'b1; irq_mask_i = '0; apply_stimulus(1);
    reset = 1'b0; pad_i = 32'h0000_0080; apply_stimulus(9);
    reset = 1'b1; apply_stimulus(1);
    check_output("t5_rst_gpio", gpio_o, 32'd0);
    check_output("t5_rst_pend", pend_o, 32'd0);
    check_output("t5_rst_rise", rise_o, 32'd0);
    reset = 1'b0; apply_stimulus(17);
    check_output("t5_gpio_before", gpio_o, 32'd0);
    apply_stimulus(1);
    check_output("t5_gpio", gpio_o, 32'h0000_0080);
    check_output("t5_rise", rise_o, 32'h0000_0080);
    apply_stimulus(1);
    check_output("t5_rise_once", rise_o, 32'd0);

    // 6: all bits rise together; zero mask keeps irq low.
    reset = 1'b1; apply_stimulus(1);
    reset = 1'b0; pad_i = 32'hFFFF_FFFF; apply_stimulus(18);
    check_output("t6_rise", rise_o, 32'hFFFF_FFFF);
    check_output("t6_pend", pend_o, 32'hFFFF_FFFF);
    check_output("t6_irq", {31'd0, irq_o}, 32'd0);
    apply_stimulus(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
